hoene_led_input_frontend: RTL and testbench

//  Input front end of the smart-LED digital core: picks one of two serial data inputs
//  (in0 or in1, whichever becomes active first) and glitch-filters the chosen stream

---
 rtl/hoene_led_input_frontend_if.sv | 12 +
 rtl/hoene_led_input_frontend.sv | 103 ++++++++++
 tb/tb_hoene_led_input_frontend.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hoene_led_input_frontend_if.sv
// Pin-side bundle of the LED input front end: two serial inputs, test select and filtered result.
interface hoene_led_input_frontend_if;
  logic in0;
  logic in1;
  logic testmode;
  logic out;
  logic in0selected;
  logic locked;

  modport master (output in0, in1, testmode, input out, in0selected, locked);
  modport slave  (input in0, in1, testmode, output out, in0selected, locked);
endinterface

// File: rtl/hoene_led_input_frontend.sv
// Smart-LED input front end: locks onto whichever serial input wakes first, then
// glitch-filters it with a saturating integrator that has hysteresis at 0 / FILTER_MAX.
module hoene_led_input_frontend #(
  parameter int FILTER_MAX   = 3,
  parameter int CNT_W        = 2,
  parameter int IDLE_TIMEOUT = 255,
  parameter int IDLE_W       = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  hoene_led_input_frontend_if.slave io
);

  typedef enum logic [1:0] {SEARCH, LOCK0, LOCK1} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FILTER_MAX);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic              s0a, s0, s1a, s1;
  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle, idle_nxt;
  logic              sel, sel_nxt, src;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              out_q, out_nxt;
  logic              in0sel_q, locked_q;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle;
    src       = (state == LOCK1) ? s1 : s0;
    if (io.testmode) begin
      state_nxt = LOCK0;
      idle_nxt  = '0;
    end else begin
      case (state)
        SEARCH: begin
          idle_nxt = '0;
          if (s0)      state_nxt = LOCK0;
          else if (s1) state_nxt = LOCK1;
        end
        LOCK0, LOCK1: begin
          if (src) idle_nxt = '0;
          else if (idle == IDLE_LAST) begin
            // source went quiet: release so the other input may take over
            state_nxt = SEARCH;
            idle_nxt  = '0;
          end else idle_nxt = idle + IDLE_W'(1);
        end
        default: begin
          state_nxt = SEARCH;
          idle_nxt  = '0;
        end
      endcase
    end

    // sel follows the state being entered, so the locking edge already forwards data
    case (state_nxt)
      LOCK0:   sel_nxt = s0;
      LOCK1:   sel_nxt = s1;
      default: sel_nxt = 1'b0;
    endcase

    if (sel) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    else     cnt_nxt = (cnt == '0)      ? cnt : cnt - CNT_W'(1);

    out_nxt = out_q;
    if (cnt_nxt == CNT_MAX) out_nxt = 1'b1;
    else if (cnt_nxt == '0) out_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s0a      <= 1'b0;
      s0       <= 1'b0;
      s1a      <= 1'b0;
      s1       <= 1'b0;
      state    <= SEARCH;
      idle     <= '0;
      sel      <= 1'b0;
      cnt      <= '0;
      out_q    <= 1'b0;
      in0sel_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      s0a      <= io.in0;
      s0       <= s0a;
      s1a      <= io.in1;
      s1       <= s1a;
      state    <= state_nxt;
      idle     <= idle_nxt;
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      out_q    <= out_nxt;
      in0sel_q <= (state_nxt == LOCK0);
      locked_q <= (state_nxt != SEARCH);
    end
  end

  assign io.out         = out_q;
  assign io.in0selected = in0sel_q;
  assign io.locked      = locked_q;

endmodule

// File: tb/tb_hoene_led_input_frontend.sv
// Directed bench: per-cycle vector table for lock/filter behaviour, hand sequences for timeout and testmode.
module tb_hoene_led_input_frontend;
  logic clk = 1'b0;
  logic rst_n;

  hoene_led_input_frontend_if io();

  hoene_led_input_frontend dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  // {rst, in0, in1, testmode, exp out, exp in0selected, exp locked}
  typedef struct packed {
    logic rst;
    logic in0;
    logic in1;
    logic tm;
    logic eo;
    logic es;
    logic el;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [6:0] v, input int n = 1);
    for (int k = 0; k < n; k++) vecs.push_back(vec_t'(v));
  endtask

  task automatic chk(input string nm, input int idx, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %b expected %b", nm, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic i0, input logic i1, input logic tm);
    rst_n       = r;
    io.in0      = i0;
    io.in1      = i1;
    io.testmode = tm;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // in0 lock, rise latency 6, fall latency 6, relock rise, mid-run reset
    add(7'b1_00_0_000);
    add(7'b0_10_0_000, 2);
    add(7'b0_10_0_011, 3);
    add(7'b0_10_0_111, 2);
    add(7'b0_00_0_111, 5);
    add(7'b0_00_0_011);
    add(7'b0_10_0_011, 5);
    add(7'b0_10_0_111);
    add(7'b1_10_0_000);
    add(7'b0_10_0_000, 2);
    add(7'b0_10_0_011, 3);
    add(7'b0_10_0_111);
    // in1 lock; in0 toggling afterwards must be ignored
    add(7'b1_00_0_000);
    add(7'b0_01_0_000, 2);
    add(7'b0_01_0_001, 3);
    add(7'b0_01_0_101);
    for (int k = 0; k < 3; k++) begin
      add(7'b0_11_0_101);
      add(7'b0_01_0_101);
    end
    // simultaneous rise picks in0; the resulting 2-cycle pulse never sets out
    add(7'b1_00_0_000);
    add(7'b0_11_0_000, 2);
    add(7'b0_00_0_011, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].in0, vecs[i].in1, vecs[i].tm);
      step();
      chk("vec_out",    i, io.out,         vecs[i].eo);
      chk("vec_in0sel", i, io.in0selected, vecs[i].es);
      chk("vec_locked", i, io.locked,      vecs[i].el);
    end

    // idle timeout on in1, then relock to in0
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step();
    chk("t4_out_hi", 0, io.out, 1'b1);
    chk("t4_locked", 0, io.locked, 1'b1);
    chk("t4_in0sel", 0, io.in0selected, 1'b0);
    io.in1 = 1'b0;
    repeat (256) step();
    chk("t4_still_locked", 0, io.locked, 1'b1);
    chk("t4_out_lo", 0, io.out, 1'b0);
    step();
    chk("t4_unlocked", 0, io.locked, 1'b0);
    chk("t4_unlocked_sel", 0, io.in0selected, 1'b0);
    io.in0 = 1'b1;
    repeat (3) step();
    chk("t4_relock_in0", 0, io.in0selected, 1'b1);
    chk("t4_relock", 0, io.locked, 1'b1);

    // testmode forces in0 and suppresses the timeout until released
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step();
    chk("t5_in1_lock", 0, io.in0selected, 1'b0);
    io.testmode = 1'b1;
    step();
    chk("t5_force_in0", 0, io.in0selected, 1'b1);
    chk("t5_force_lock", 0, io.locked, 1'b1);
    io.in1 = 1'b0;
    repeat (1000) step();
    chk("t5_hold_lock", 0, io.locked, 1'b1);
    chk("t5_hold_in0", 0, io.in0selected, 1'b1);
    chk("t5_out_lo", 0, io.out, 1'b0);
    io.testmode = 1'b0;
    repeat (254) step();
    chk("t5_resume_locked", 0, io.locked, 1'b1);
    step();
    chk("t5_resume_timeout", 0, io.locked, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
